mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single synchronous BRAM behind the SLC-3 datapath. Port 0 serves the CPU control unit's MAR/MDR accesses; port 1 serves the debug/program-loader DMA. The block grants one requester at a time using round-robin arbitration. It drives the BRAM enable, write, address and data lines, waits out the BRAM's fixed read latency, and returns a one-cycle acknowledge with captured read data. The CPU control unit therefore replaces its fixed wait states with a req/ack handshake.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 88 ++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single synchronous BRAM.
// The arbiter takes the slave view; the requester/BRAM side takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_ena;
  logic          mem_wr_ena;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, busy, mem_ena, mem_wr_ena, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, busy, mem_ena, mem_wr_ena, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port BRAM arbiter: write acks 2 cycles after request, read acks RD_LAT+2 after.
// Requests are sampled only in IDLE; a requester simply holds req until its one-cycle ack.
module mem_arbiter #(
  parameter int RD_LAT = 2,
  parameter int AW     = 16,
  parameter int DW     = 16
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]    state;
  logic          last_grant;
  logic          grant;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata_q;
  logic [2:0]    cnt;
  logic          any_req;
  logic          next_grant;

  // On contention the port that did not win last time is served.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      next_grant = ~last_grant;
    end else begin
      next_grant = bus.req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      cnt        <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            lat_we     <= next_grant ? bus.we1 : bus.we0;
            lat_addr   <= next_grant ? bus.addr1 : bus.addr0;
            lat_wdata  <= next_grant ? bus.wdata1 : bus.wdata0;
            state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_we) begin
            state <= S_ACK;
          end else begin
            cnt   <= 3'(RD_LAT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rdata_q <= bus.mem_rdata;
            state   <= S_ACK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0       = (state == S_ACK) && !grant;
  assign bus.ack1       = (state == S_ACK) && grant;
  assign bus.busy       = (state != S_IDLE);
  assign bus.mem_ena    = (state == S_ACCESS);
  assign bus.mem_wr_ena = (state == S_ACCESS) && lat_we;
  assign bus.mem_addr   = (state == S_IDLE) ? '0 : lat_addr;
  assign bus.mem_wdata  = (state == S_IDLE) ? '0 : lat_wdata;
  assign bus.rdata      = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RD_LAT=2 and RD_LAT=3 instances, each with its own BRAM model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) ifa ();
  mem_arbiter_if #(.AW(16), .DW(16)) ifb ();

  mem_arbiter #(.RD_LAT(2), .AW(16), .DW(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mem_arbiter #(.RD_LAT(3), .AW(16), .DW(16)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // BRAM models: read data emerges RD_LAT cycles after the enable cycle, garbage otherwise.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] pipe_a [0:1];
  logic [15:0] pipe_b [0:2];
  logic        pre_we_a, pre_we_b;
  logic [15:0] pre_addr, pre_dat;

  always @(posedge clk) begin
    if (pre_we_a) mem_a[pre_addr] <= pre_dat;
    else if (ifa.mem_ena && ifa.mem_wr_ena) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
    pipe_a[0] <= (ifa.mem_ena && !ifa.mem_wr_ena) ? mem_a[ifa.mem_addr] : 16'hDEAD;
    pipe_a[1] <= pipe_a[0];
  end

  always @(posedge clk) begin
    if (pre_we_b) mem_b[pre_addr] <= pre_dat;
    else if (ifb.mem_ena && ifb.mem_wr_ena) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
    pipe_b[0] <= (ifb.mem_ena && !ifb.mem_wr_ena) ? mem_b[ifb.mem_addr] : 16'hDEAD;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign ifa.mem_rdata = pipe_a[1];
  assign ifb.mem_rdata = pipe_b[2];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [5];

  task automatic chk1(input string nm, input int c, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input bit port, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (!sel && !port) begin ifa.req0 = r; ifa.we0 = w; ifa.addr0 = a; ifa.wdata0 = d; end
    if (!sel &&  port) begin ifa.req1 = r; ifa.we1 = w; ifa.addr1 = a; ifa.wdata1 = d; end
    if ( sel && !port) begin ifb.req0 = r; ifb.we0 = w; ifb.addr0 = a; ifb.wdata0 = d; end
    if ( sel &&  port) begin ifb.req1 = r; ifb.we1 = w; ifb.addr1 = a; ifb.wdata1 = d; end
  endtask

  task automatic sample(input bit sel, output logic a0, output logic a1, output logic bz,
                        output logic en, output logic wr, output logic [15:0] ad,
                        output logic [15:0] rd);
    if (sel) begin
      a0 = ifb.ack0; a1 = ifb.ack1; bz = ifb.busy; en = ifb.mem_ena;
      wr = ifb.mem_wr_ena; ad = ifb.mem_addr; rd = ifb.rdata;
    end else begin
      a0 = ifa.ack0; a1 = ifa.ack1; bz = ifa.busy; en = ifa.mem_ena;
      wr = ifa.mem_wr_ena; ad = ifa.mem_addr; rd = ifa.rdata;
    end
  endtask

  task automatic preload(input bit sel, input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_dat  = d;
    if (sel) pre_we_b = 1'b1; else pre_we_a = 1'b1;
    tick();
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Single-requester transaction starting in an IDLE cycle (cycle 0); returns in the next IDLE cycle.
  task automatic txn(input bit sel, input vec_t v);
    logic a0, a1, bz, en, wr;
    logic [15:0] ad, rd;
    int lat;
    int last;
    lat  = sel ? 3 : 2;
    last = v.we ? 2 : lat + 2;
    drive(sel, v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      sample(sel, a0, a1, bz, en, wr, ad, rd);
      chk1("mem_ena", c, en, c == 1);
      chk1("mem_wr_ena", c, wr, (c == 1) && v.we);
      chk1("busy", c, bz, c >= 1);
      chk1(v.port ? "ack1" : "ack0", c, v.port ? a1 : a0, c == last);
      chk1(v.port ? "ack0_idle" : "ack1_idle", c, v.port ? a0 : a1, 1'b0);
      if (c >= 1) chk16("mem_addr", c, ad, v.addr);
      if (c == last) chk16("rdata", c, rd, v.exp_rd);
      tick();
      if (c == 0) drive(sel, v.port, 1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    logic a0, a1, bz, en, wr;
    logic [15:0] ad, rd;

    tbl[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234};
    tbl[3] = '{1'b0, 1'b1, 16'h0020, 16'h5A5A, 16'h1234};
    tbl[4] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A};

    pre_we_a = 1'b0; pre_we_b = 1'b0; pre_addr = '0; pre_dat = '0;
    drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    reset = 1'b1;
    preload(0, 16'h3000, 16'hBEEF);
    preload(0, 16'h0100, 16'h1111);
    preload(0, 16'h0200, 16'h2222);
    preload(1, 16'h0040, 16'hC0DE);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s[0], a0, a1, bz, en, wr, ad, rd);
      chk1("rst_ack0", 0, a0, 1'b0);
      chk1("rst_ack1", 0, a1, 1'b0);
      chk1("rst_busy", 0, bz, 1'b0);
      chk1("rst_mem_ena", 0, en, 1'b0);
      chk1("rst_mem_wr_ena", 0, wr, 1'b0);
      chk16("rst_mem_addr", 0, ad, 16'h0);
      chk16("rst_rdata", 0, rd, 16'h0);
      chk16("rst_mem_wdata", 0, s[0] ? ifb.mem_wdata : ifa.mem_wdata, 16'h0);
    end
    chk1("rst_last_grant", 0, dut_a.last_grant, 1'b1);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) txn(0, tbl[i]);

    // Contention: both ports read continuously, grants alternate starting with port 0.
    do_reset();
    drive(0, 0, 1, 0, 16'h0100, 0);
    drive(0, 1, 1, 0, 16'h0200, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk1("cont_ack0", c, ifa.ack0, (c == 4) || (c == 14));
      chk1("cont_ack1", c, ifa.ack1, (c == 9) || (c == 19));
      if (ifa.ack0) chk16("cont_rdata0", c, ifa.rdata, 16'h1111);
      if (ifa.ack1) chk16("cont_rdata1", c, ifa.rdata, 16'h2222);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    tick();

    // Inputs changed during WAIT must not disturb the latched read.
    drive(0, 0, 1, 0, 16'h3000, 0);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk1("late_wr_ena", c, ifa.mem_wr_ena, 1'b0);
      chk1("late_ack0", c, ifa.ack0, c == 4);
      if (c >= 1) chk16("late_mem_addr", c, ifa.mem_addr, 16'h3000);
      if (c == 4) chk16("late_rdata", c, ifa.rdata, 16'hBEEF);
      tick();
      if (c == 0) drive(0, 0, 0, 0, 16'h3000, 0);
      if (c == 1) drive(0, 0, 0, 1, 16'h0020, 16'hFFFF);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk16("late_mem_untouched", 0, mem_a[16'h0020], 16'h5A5A);

    // Reset during WAIT aborts the read; last_grant (0 here) returns to 1.
    drive(0, 0, 1, 0, 16'h3000, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("rstw_busy", 3, ifa.busy, 1'b0);
    chk16("rstw_rdata", 3, ifa.rdata, 16'h0);
    chk1("rstw_last_grant", 3, dut_a.last_grant, 1'b1);
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      chk1("rstw_no_ack0", c, ifa.ack0, 1'b0);
      tick();
    end
    drive(0, 0, 1, 0, 16'h0100, 0);
    drive(0, 1, 1, 0, 16'h0200, 0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk1("rstw_ack0", c, ifa.ack0, c == 4);
      chk1("rstw_ack1", c, ifa.ack1, 1'b0);
      if (c == 4) chk16("rstw_rdata0", c, ifa.rdata, 16'h1111);
      tick();
      if (c == 0) begin
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
      end
    end

    // RD_LAT = 3 instance.
    txn(1, '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hC0DE});
    txn(1, '{1'b1, 1'b1, 16'h0041, 16'h7777, 16'hC0DE});
    txn(1, '{1'b1, 1'b0, 16'h0041, 16'h0000, 16'h7777});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
